mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sits between the two memory requesters (instruction fetch and load/store buffer) and the single byte-serial memory controller. Latches one request at a time, drives the controller's request interface, waits for its completion strobe, and returns the data to the granted requester with a one-cycle done pulse. It also handles flush of an in-flight fetch and holds its state while `rdy_in` is low.

Parameters:
ADDR_W, 32, address width of all request/response buses
DATA_W, 32, data width of all request/response buses

Ports:
clk_in  input  1  system clock; all state on rising edge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low = hold every register
if_req_in  input  1  fetch request; held high until if_done_out
if_addr_in  input  32  fetch address; always word read
if_done_out  output  1  one-cycle pulse; if_data_out valid
if_data_out  output  32  fetched word
ls_req_in  input  1  load/store request; held high until ls_done_out
ls_addr_in  input  32  load/store address
ls_data_in  input  32  store data
ls_r_nw_in  input  1  1 = load, 0 = store
ls_type_in  input  3  [1:0] 00 word, 01 half, 10 byte; [2] 1 = unsigned
ls_done_out  output  1  one-cycle pulse; ls_data_out valid for loads
ls_data_out  output  32  load result, extended by the controller
flush_in  input  1  discard the pending/in-flight fetch result
mc_activate_out  output  1  request strobe to the memory controller
mc_addr_out  output  32  controller address
mc_data_out  output  32  controller write data
mc_r_nw_out  output  1  controller read/write select
mc_type_out  output  3  controller access type
mc_data_in  input  32  controller read data
mc_available_in  input  1  controller completion strobe; one cycle

Behaviour:
- Reset (sync, `rst_in` = 1 at posedge):
  - state <= IDLE, owner <= IF, last_grant <= IF, kill <= 0.
  - All mc_* outputs 0.
  - if_done_out = ls_done_out = 0.
  - if_data_out = ls_data_out = 0.
  - Reset mid-transaction abandons it. No done pulse is issued afterwards.
- `rdy_in` = 0: no register changes. Done pulses are held, not repeated.
- States:
  - IDLE
    - Sample requests.
    - Grant rule: ls_req_in only -> LS; if_req_in only -> IF; both -> LS.
    - If if_req_in = 1 and flush_in = 1 in the same cycle, IF is not granted.
    - On grant: latch addr/data/r_nw/type into the mc_* registers and go to BUSY.
    - IF grant latches r_nw = 1, type = 000, data = 0.
  - BUSY
    - mc_activate_out = 1 and mc_* outputs are stable for the whole state.
    - When mc_available_in = 1: capture mc_data_in into the owner's data register.
    - mc_activate_out drops to 0 at the following edge, and the state moves to RESP.
  - RESP
    - Exactly one cycle. mc_activate_out = 0.
    - Owner's done pulses high, except an IF owner with kill = 1: no pulse, data discarded.
    - Clear kill; go to IDLE.
    - No grant is evaluated in RESP. Requesters must drop req by the cycle after done, which prevents a duplicate grant.
- mc_activate_out is registered: `(next_state == BUSY)`. It is never high in IDLE or RESP, so the controller's self-clearing available cycle is respected.
- Flush:
  - flush_in in BUSY or RESP with owner = IF sets kill. The controller read is allowed to finish (it cannot be aborted); only the result is dropped.
  - Flush never affects an LS transaction.
- Latency: grant edge -> mc_activate_out high on the next cycle. done_out is asserted 1 cycle after mc_available_in. The minimum IDLE-to-IDLE round trip is controller latency + 2 cycles.
- Stores: ls_done_out pulses; ls_data_out holds the value captured from mc_data_in, which is don't-care.
- Requests arriving while BUSY/RESP wait; nothing is queued beyond the requester's held req.

Optional Feature:
MEM_ARB_RR_EN
- Defined: when both requests are present in IDLE, grant the requester opposite to last_grant (round-robin). last_grant updates on every grant.
- Undefined: fixed LS-over-IF priority; last_grant unused.

Test Plan:
- IF only, addr 0x0000_1000, controller returns 0xDEAD_BEEF:
  - mc_activate_out = 1, mc_addr_out = 0x1000, mc_r_nw_out = 1, mc_type_out = 000.
  - if_done_out pulses once, 1 cycle after mc_available_in, with if_data_out = 0xDEAD_BEEF.
  - No second grant.
- LS store byte, addr 0x30000, data 0x41, type 010:
  - mc_r_nw_out = 0, mc_data_out = 0x41.
  - ls_done_out single pulse; if_done_out stays 0.
- Both req in the same cycle:
  - LS granted first, IF second.
  - With MEM_ARB_RR_EN and last_grant = LS, IF is granted first.
- flush_in during BUSY with IF owner:
  - The transaction completes at the controller.
  - if_done_out never pulses.
  - A new IF request afterwards returns correct data.
- rdy_in low for 3 cycles mid-BUSY and during RESP:
  - Outputs are frozen.
  - Exactly one done pulse after rdy_in returns.
- rst_in asserted during BUSY:
  - All outputs are 0 next cycle and the state is IDLE.
  - A late mc_available_in produces no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and load/store for a single byte-serial memory controller.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,

    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [DATA_W-1:0] if_data_out,

    input  logic              ls_req_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_data_in,
    input  logic              ls_r_nw_in,
    input  logic [2:0]        ls_type_in,
    output logic              ls_done_out,
    output logic [DATA_W-1:0] ls_data_out,

    input  logic              flush_in,

    output logic              mc_activate_out,
    output logic [ADDR_W-1:0] mc_addr_out,
    output logic [DATA_W-1:0] mc_data_out,
    output logic              mc_r_nw_out,
    output logic [2:0]        mc_type_out,
    input  logic [DATA_W-1:0] mc_data_in,
    input  logic              mc_available_in
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;
    typedef enum logic {OwnIf, OwnLs} owner_t;

    state_t state_q;
    owner_t owner_q;
    logic   kill_q;
    logic   pick_if;
    logic   grant_ls;
    logic   grant_if;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant_q;
`endif

    // A fetch that is being flushed in the same cycle is never granted.
    always_comb begin
        pick_if = 1'b0;
`ifdef MEM_ARB_RR_EN
        pick_if = (last_grant_q == OwnLs);
`endif
        grant_ls = ls_req_in && !(if_req_in && !flush_in && pick_if);
        grant_if = if_req_in && !flush_in && !grant_ls;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= StIdle;
            owner_q         <= OwnIf;
            kill_q          <= 1'b0;
            mc_activate_out <= 1'b0;
            mc_addr_out     <= '0;
            mc_data_out     <= '0;
            mc_r_nw_out     <= 1'b0;
            mc_type_out     <= 3'b000;
            if_done_out     <= 1'b0;
            ls_done_out     <= 1'b0;
            if_data_out     <= '0;
            ls_data_out     <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q    <= OwnIf;
`endif
        end else if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    if (grant_ls) begin
                        owner_q         <= OwnLs;
                        mc_addr_out     <= ls_addr_in;
                        mc_data_out     <= ls_data_in;
                        mc_r_nw_out     <= ls_r_nw_in;
                        mc_type_out     <= ls_type_in;
                        mc_activate_out <= 1'b1;
                        state_q         <= StBusy;
`ifdef MEM_ARB_RR_EN
                        last_grant_q    <= OwnLs;
`endif
                    end else if (grant_if) begin
                        owner_q         <= OwnIf;
                        mc_addr_out     <= if_addr_in;
                        mc_data_out     <= '0;
                        mc_r_nw_out     <= 1'b1;
                        mc_type_out     <= 3'b000;
                        mc_activate_out <= 1'b1;
                        state_q         <= StBusy;
`ifdef MEM_ARB_RR_EN
                        last_grant_q    <= OwnIf;
`endif
                    end
                end
                StBusy: begin
                    if (flush_in && owner_q == OwnIf) begin
                        kill_q <= 1'b1;
                    end
                    if (mc_available_in) begin
                        mc_activate_out <= 1'b0;
                        state_q         <= StResp;
                        if (owner_q == OwnLs) begin
                            ls_data_out <= mc_data_in;
                            ls_done_out <= 1'b1;
                        end else if (!(kill_q || flush_in)) begin
                            if_data_out <= mc_data_in;
                            if_done_out <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    // No grant here: requesters drop req in this cycle.
                    if_done_out <= 1'b0;
                    ls_done_out <= 1'b0;
                    kill_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    mc_activate_out <= 1'b0;
                    state_q         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; honours MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        if_req_in, ls_req_in, ls_r_nw_in, mc_available_in;
    logic [31:0] if_addr_in, ls_addr_in, ls_data_in, mc_data_in;
    logic [2:0]  ls_type_in;
    logic        if_done_out, ls_done_out, mc_activate_out, mc_r_nw_out;
    logic [31:0] if_data_out, ls_data_out, mc_addr_out, mc_data_out;
    logic [2:0]  mc_type_out;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_if_data;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_req_in(ls_req_in), .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
        .ls_r_nw_in(ls_r_nw_in), .ls_type_in(ls_type_in),
        .ls_done_out(ls_done_out), .ls_data_out(ls_data_out),
        .flush_in(flush_in),
        .mc_activate_out(mc_activate_out), .mc_addr_out(mc_addr_out),
        .mc_data_out(mc_data_out), .mc_r_nw_out(mc_r_nw_out), .mc_type_out(mc_type_out),
        .mc_data_in(mc_data_in), .mc_available_in(mc_available_in)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        if_req_in = 1'b0; ls_req_in = 1'b0; ls_r_nw_in = 1'b1; mc_available_in = 1'b0;
        if_addr_in = '0; ls_addr_in = '0; ls_data_in = '0; mc_data_in = '0; ls_type_in = '0;
        tick(); tick();
        rst_in = 1'b0;
        n_checks++;
        if (mc_activate_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_act: got %0b want 0", mc_activate_out);
        end
        n_checks++;
        if ({if_done_out, ls_done_out} !== 2'b00) begin
            n_fail++; $display("FAIL rst_done: got %b want 00", {if_done_out, ls_done_out});
        end
        n_checks++;
        if ({if_data_out, ls_data_out} !== 64'h0) begin
            n_fail++; $display("FAIL rst_data: got %h/%h want 0", if_data_out, ls_data_out);
        end
        n_checks++;
        if ({mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out} !== 68'h0) begin
            n_fail++; $display("FAIL rst_mc: got %h %h %b %b want 0", mc_addr_out, mc_data_out,
                               mc_r_nw_out, mc_type_out);
        end
    endtask

    task automatic test_if_read();
        if_req_in = 1'b1; if_addr_in = 32'h0000_1000;
        tick();
        n_checks++;
        if ({mc_activate_out, mc_addr_out, mc_r_nw_out, mc_type_out} !== {1'b1, 32'h1000, 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL if_issue: got act=%0b addr=%h rnw=%0b type=%b want 1 1000 1 000",
                               mc_activate_out, mc_addr_out, mc_r_nw_out, mc_type_out);
        end
        tick(); tick();
        n_checks++;
        if ({mc_activate_out, if_done_out} !== 2'b10) begin
            n_fail++; $display("FAIL if_wait: got act/done=%b want 10", {mc_activate_out, if_done_out});
        end
        mc_available_in = 1'b1; mc_data_in = 32'hDEAD_BEEF;
        tick();
        mc_available_in = 1'b0; if_req_in = 1'b0;
        n_checks++;
        if ({mc_activate_out, if_done_out, if_data_out} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL if_done: got act=%0b done=%0b data=%h want 0 1 deadbeef",
                               mc_activate_out, if_done_out, if_data_out);
        end
        exp_if_data = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (if_done_out !== 1'b0) begin
            n_fail++; $display("FAIL if_pulse_len: got %0b want 0", if_done_out);
        end
        tick();
        n_checks++;
        if ({mc_activate_out, if_done_out} !== 2'b00) begin
            n_fail++; $display("FAIL if_no_regrant: got act/done=%b want 00",
                               {mc_activate_out, if_done_out});
        end
    endtask

    task automatic test_ls_store();
        ls_req_in = 1'b1; ls_addr_in = 32'h0003_0000; ls_data_in = 32'h41;
        ls_r_nw_in = 1'b0; ls_type_in = 3'b010;
        tick();
        n_checks++;
        if ({mc_activate_out, mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out} !==
            {1'b1, 32'h0003_0000, 32'h41, 1'b0, 3'b010}) begin
            n_fail++; $display("FAIL st_issue: got act=%0b addr=%h data=%h rnw=%0b type=%b",
                               mc_activate_out, mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out);
        end
        mc_available_in = 1'b1; mc_data_in = 32'h1234_5678;
        tick();
        mc_available_in = 1'b0; ls_req_in = 1'b0;
        n_checks++;
        if ({ls_done_out, if_done_out, mc_activate_out} !== 3'b100) begin
            n_fail++; $display("FAIL st_done: got ls/if/act=%b want 100",
                               {ls_done_out, if_done_out, mc_activate_out});
        end
        tick();
        n_checks++;
        if ({ls_done_out, if_done_out} !== 2'b00) begin
            n_fail++; $display("FAIL st_pulse_len: got %b want 00", {ls_done_out, if_done_out});
        end
        tick();
        n_checks++;
        if ({mc_activate_out, ls_done_out, if_done_out} !== 3'b000) begin
            n_fail++; $display("FAIL st_no_regrant: got %b want 000",
                               {mc_activate_out, ls_done_out, if_done_out});
        end
    endtask

    task automatic test_both();
        logic first_ls;
`ifdef MEM_ARB_RR_EN
        first_ls = 1'b0;  // last grant was the store, so fetch wins
`else
        first_ls = 1'b1;
`endif
        if_req_in = 1'b1; if_addr_in = 32'h0000_2000;
        ls_req_in = 1'b1; ls_addr_in = 32'h0000_0400; ls_r_nw_in = 1'b1; ls_type_in = 3'b000;
        tick();
        n_checks++;
        if (mc_addr_out !== (first_ls ? 32'h400 : 32'h2000)) begin
            n_fail++; $display("FAIL both_first: got addr=%h want %h", mc_addr_out,
                               first_ls ? 32'h400 : 32'h2000);
        end
        mc_available_in = 1'b1; mc_data_in = 32'hAAAA_0001;
        tick();
        mc_available_in = 1'b0;
        n_checks++;
        if ({ls_done_out, if_done_out} !== (first_ls ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL both_done1: got ls/if=%b", {ls_done_out, if_done_out});
        end
        if (first_ls) ls_req_in = 1'b0; else if_req_in = 1'b0;
        if (!first_ls) exp_if_data = 32'hAAAA_0001;
        tick();
        tick();
        n_checks++;
        if ({mc_activate_out, mc_addr_out} !== {1'b1, first_ls ? 32'h2000 : 32'h400}) begin
            n_fail++; $display("FAIL both_second: got act=%0b addr=%h", mc_activate_out, mc_addr_out);
        end
        mc_available_in = 1'b1; mc_data_in = 32'hAAAA_0002;
        tick();
        mc_available_in = 1'b0; if_req_in = 1'b0; ls_req_in = 1'b0;
        n_checks++;
        if ({ls_done_out, if_done_out} !== (first_ls ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL both_done2: got ls/if=%b", {ls_done_out, if_done_out});
        end
        if (first_ls) exp_if_data = 32'hAAAA_0002;
        n_checks++;
        if (if_data_out !== exp_if_data) begin
            n_fail++; $display("FAIL both_if_data: got %h want %h", if_data_out, exp_if_data);
        end
        tick(); tick();
    endtask

    task automatic test_flush();
        if_req_in = 1'b1; if_addr_in = 32'h0000_5000;
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        n_checks++;
        if (mc_activate_out !== 1'b1) begin
            n_fail++; $display("FAIL fl_busy: got act=%0b want 1", mc_activate_out);
        end
        if_req_in = 1'b0;
        mc_available_in = 1'b1; mc_data_in = 32'h0BAD_0BAD;
        tick();
        mc_available_in = 1'b0;
        n_checks++;
        if ({mc_activate_out, if_done_out, if_data_out} !== {2'b00, exp_if_data}) begin
            n_fail++; $display("FAIL fl_killed: got act=%0b done=%0b data=%h want 0 0 %h",
                               mc_activate_out, if_done_out, if_data_out, exp_if_data);
        end
        tick();
        n_checks++;
        if (if_done_out !== 1'b0) begin
            n_fail++; $display("FAIL fl_resp: got done=%0b want 0", if_done_out);
        end
        if_req_in = 1'b1; if_addr_in = 32'h0000_5004;
        tick();
        n_checks++;
        if ({mc_activate_out, mc_addr_out} !== {1'b1, 32'h5004}) begin
            n_fail++; $display("FAIL fl_refetch: got act=%0b addr=%h", mc_activate_out, mc_addr_out);
        end
        mc_available_in = 1'b1; mc_data_in = 32'hCAFE_F00D;
        tick();
        mc_available_in = 1'b0; if_req_in = 1'b0;
        n_checks++;
        if ({if_done_out, if_data_out} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL fl_after: got done=%0b data=%h want 1 cafef00d",
                               if_done_out, if_data_out);
        end
        exp_if_data = 32'hCAFE_F00D;
        tick(); tick();
    endtask

    task automatic test_rdy();
        int pulses;
        pulses = 0;
        ls_req_in = 1'b1; ls_addr_in = 32'h40; ls_r_nw_in = 1'b1; ls_type_in = 3'b000;
        tick();
        rdy_in = 1'b0; mc_available_in = 1'b1; mc_data_in = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({mc_activate_out, ls_done_out, mc_addr_out} !== {2'b10, 32'h40}) begin
                n_fail++; $display("FAIL rdy_busy_hold%0d: got act=%0b done=%0b addr=%h",
                                   i, mc_activate_out, ls_done_out, mc_addr_out);
            end
        end
        rdy_in = 1'b1;
        tick();
        mc_available_in = 1'b0; ls_req_in = 1'b0;
        n_checks++;
        if ({ls_done_out, ls_data_out, mc_activate_out} !== {1'b1, 32'h55, 1'b0}) begin
            n_fail++; $display("FAIL rdy_done: got done=%0b data=%h act=%0b want 1 55 0",
                               ls_done_out, ls_data_out, mc_activate_out);
        end
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({ls_done_out, mc_activate_out} !== 2'b10) begin
                n_fail++; $display("FAIL rdy_resp_hold%0d: got done/act=%b want 10",
                                   i, {ls_done_out, mc_activate_out});
            end
        end
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ls_done_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL rdy_repeat: got %0d extra done cycles want 0", pulses);
        end
    endtask

    task automatic test_reset_busy();
        if_req_in = 1'b1; if_addr_in = 32'h0000_3000;
        tick();
        n_checks++;
        if (mc_activate_out !== 1'b1) begin
            n_fail++; $display("FAIL rb_issue: got act=%0b want 1", mc_activate_out);
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0; if_req_in = 1'b0;
        n_checks++;
        if ({mc_activate_out, mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out,
             if_done_out, ls_done_out, if_data_out, ls_data_out} !== 135'h0) begin
            n_fail++; $display("FAIL rb_outputs: got act=%0b addr=%h rnw=%0b idata=%h ldata=%h",
                               mc_activate_out, mc_addr_out, mc_r_nw_out, if_data_out, ls_data_out);
        end
        mc_available_in = 1'b1; mc_data_in = 32'h77;
        tick();
        mc_available_in = 1'b0;
        n_checks++;
        if ({if_done_out, ls_done_out, mc_activate_out} !== 3'b000) begin
            n_fail++; $display("FAIL rb_late_avail: got if/ls/act=%b want 000",
                               {if_done_out, ls_done_out, mc_activate_out});
        end
        tick();
        n_checks++;
        if ({if_done_out, if_data_out} !== 33'h0) begin
            n_fail++; $display("FAIL rb_after: got done=%0b data=%h want 0 0",
                               if_done_out, if_data_out);
        end
    endtask

    initial begin
        exp_if_data = '0;
        test_reset();
        test_if_read();
        test_ls_store();
        test_both();
        test_flush();
        test_rdy();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
